// File: rtl/sal_addr_decoder_dual.sv
// sal_addr_decoder_dual
//   AXI AR/AW address decoder and bank dispatcher. Both address channels are
//   decoded in parallel into {bank, row, column}. Each bank owns one
//   registered request slot, so an accepted request appears on the bank
//   interface one cycle later. When AR and AW target the same bank in the
//   same cycle, AW wins unless AR has already lost STARVE_MAX conflicts in a
//   row; then AR is forced through.
//
//   Optional feature macro: SAL_BA_XOR_HASH_EN
//     defined     : effective bank = decoded BA ^ RA[BA_W-1:0]
//     not defined : effective bank = decoded BA
//
//   Handshake semantics (all channels): a transfer happens on a rising clk
//   edge where valid and ready are both 1. ar_ready/aw_ready are pure
//   functions of both channels' valid/addr, slot occupancy, req_ready and
//   the starvation counter; neither ready looks at the other ready. A bank
//   slot holds its contents unchanged while req_valid[b] & !req_ready[b].
module sal_addr_decoder_dual #(
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int LEN_W      = 8,
  parameter int SEQ_W      = 8,
  parameter int BA_W       = 2,
  parameter int RA_W       = 14,
  parameter int CA_W       = 10,
  parameter int OFS_W      = 6,
  parameter int MAP_MODE   = 0,
  parameter int STARVE_MAX = 4,
  localparam int BK_CNT    = 2 ** BA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // AR slave
  input  logic                     ar_valid,
  output logic                     ar_ready,
  input  logic [ID_W-1:0]          ar_id,
  input  logic [LEN_W-1:0]         ar_len,
  input  logic [ADDR_W-1:0]        ar_addr,
  // AW slave
  input  logic                     aw_valid,
  output logic                     aw_ready,
  input  logic [ID_W-1:0]          aw_id,
  input  logic [LEN_W-1:0]         aw_len,
  input  logic [ADDR_W-1:0]        aw_addr,
  // Bank controller requests, bank b packed at [b*W +: W]
  output logic [BK_CNT-1:0]        req_valid,
  input  logic [BK_CNT-1:0]        req_ready,
  output logic [BK_CNT-1:0]        req_wr,
  output logic [BK_CNT*ID_W-1:0]   req_id,
  output logic [BK_CNT*LEN_W-1:0]  req_len,
  output logic [BK_CNT*SEQ_W-1:0]  req_seq_num,
  output logic [BK_CNT*RA_W-1:0]   req_ra,
  output logic [BK_CNT*CA_W-1:0]   req_ca
);

  // Starvation counter must be able to hold STARVE_MAX (which is >= 1).
  localparam int              ST_W       = $clog2(STARVE_MAX + 1);
  localparam logic [ST_W-1:0] STARVE_LIM = ST_W'(STARVE_MAX);

  typedef struct packed {
    logic [BA_W-1:0] ba;
    logic [RA_W-1:0] ra;
    logic [CA_W-1:0] ca;
  } dec_t;

  // Slice an address into bank/row/column; bits above the mapped field
  // and the byte offset are ignored.
  function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
    dec_t d;
    if (MAP_MODE == 0) begin
      d.ca = addr[OFS_W +: CA_W];
      d.ba = addr[OFS_W + CA_W +: BA_W];
    end else begin
      d.ba = addr[OFS_W +: BA_W];
      d.ca = addr[OFS_W + BA_W +: CA_W];
    end
    d.ra = addr[OFS_W + BA_W + CA_W +: RA_W];
`ifdef SAL_BA_XOR_HASH_EN
    d.ba = d.ba ^ d.ra[BA_W-1:0];
`endif
    return d;
  endfunction

  // Offset and high address bits are intentionally dropped by the decode.
  logic unused_addr;
  assign unused_addr = ^{ar_addr, aw_addr};

  // Per-bank request slots
  logic [BK_CNT-1:0] slot_vld_q, slot_vld_d;
  logic [BK_CNT-1:0] slot_wr_q,  slot_wr_d;
  logic [ID_W-1:0]   slot_id_q  [BK_CNT];
  logic [ID_W-1:0]   slot_id_d  [BK_CNT];
  logic [LEN_W-1:0]  slot_len_q [BK_CNT];
  logic [LEN_W-1:0]  slot_len_d [BK_CNT];
  logic [SEQ_W-1:0]  slot_seq_q [BK_CNT];
  logic [SEQ_W-1:0]  slot_seq_d [BK_CNT];
  logic [RA_W-1:0]   slot_ra_q  [BK_CNT];
  logic [RA_W-1:0]   slot_ra_d  [BK_CNT];
  logic [CA_W-1:0]   slot_ca_q  [BK_CNT];
  logic [CA_W-1:0]   slot_ca_d  [BK_CNT];

  // Sequence counters and AR starvation counter
  logic [SEQ_W-1:0] rd_seq_q, rd_seq_d;
  logic [SEQ_W-1:0] wr_seq_q, wr_seq_d;
  logic [ST_W-1:0]  starve_q, starve_d;

  // Decode and arbitration signals
  dec_t              ar_dec, aw_dec;
  logic [BK_CNT-1:0] slot_free;
  logic              conflict;
  logic              ar_pri;
  logic              ar_acc, aw_acc;

  // Decode both channels in parallel.
  always_comb begin
    ar_dec = decode(ar_addr);
    aw_dec = decode(aw_addr);
  end

  // A slot can take a new request when empty or being drained this cycle.
  assign slot_free = ~slot_vld_q | req_ready;

  // Same-bank conflict arbitration; AR gets priority once starved.
  always_comb begin
    conflict = ar_valid & aw_valid & (ar_dec.ba == aw_dec.ba);
    ar_pri   = (starve_q == STARVE_LIM);
    ar_ready = rst_n & slot_free[ar_dec.ba] & ~(conflict & ~ar_pri);
    aw_ready = rst_n & slot_free[aw_dec.ba] & ~(conflict & ar_pri);
    ar_acc   = ar_valid & ar_ready;
    aw_acc   = aw_valid & aw_ready;
  end

  // Starvation counter: count AW conflict wins, clear on AR accept.
  always_comb begin
    starve_d = starve_q;
    if (ar_acc) begin
      starve_d = '0;
    end else if (conflict && aw_acc && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Sequence counters advance once per accepted request, wrapping naturally.
  always_comb begin
    rd_seq_d = rd_seq_q;
    wr_seq_d = wr_seq_q;
    if (ar_acc) rd_seq_d = rd_seq_q + 1'b1;
    if (aw_acc) wr_seq_d = wr_seq_q + 1'b1;
  end

  // Slot next state: load on accept, clear on pop, otherwise hold.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_wr_d  = slot_wr_q;
    slot_id_d  = slot_id_q;
    slot_len_d = slot_len_q;
    slot_seq_d = slot_seq_q;
    slot_ra_d  = slot_ra_q;
    slot_ca_d  = slot_ca_q;
    for (int b = 0; b < BK_CNT; b++) begin
      if (slot_vld_q[b] && req_ready[b]) begin
        slot_vld_d[b] = 1'b0;
      end
      // Arbitration guarantees at most one channel loads a given bank.
      if (ar_acc && (ar_dec.ba == BA_W'(b))) begin
        slot_vld_d[b] = 1'b1;
        slot_wr_d[b]  = 1'b0;
        slot_id_d[b]  = ar_id;
        slot_len_d[b] = ar_len;
        slot_seq_d[b] = rd_seq_q;
        slot_ra_d[b]  = ar_dec.ra;
        slot_ca_d[b]  = ar_dec.ca;
      end else if (aw_acc && (aw_dec.ba == BA_W'(b))) begin
        slot_vld_d[b] = 1'b1;
        slot_wr_d[b]  = 1'b1;
        slot_id_d[b]  = aw_id;
        slot_len_d[b] = aw_len;
        slot_seq_d[b] = wr_seq_q;
        slot_ra_d[b]  = aw_dec.ra;
        slot_ca_d[b]  = aw_dec.ca;
      end
    end
  end

  // State registers; synchronous reset drops any pending slot contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      slot_wr_q  <= '0;
      for (int b = 0; b < BK_CNT; b++) begin
        slot_id_q[b]  <= '0;
        slot_len_q[b] <= '0;
        slot_seq_q[b] <= '0;
        slot_ra_q[b]  <= '0;
        slot_ca_q[b]  <= '0;
      end
      rd_seq_q <= '0;
      wr_seq_q <= '0;
      starve_q <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_wr_q  <= slot_wr_d;
      slot_id_q  <= slot_id_d;
      slot_len_q <= slot_len_d;
      slot_seq_q <= slot_seq_d;
      slot_ra_q  <= slot_ra_d;
      slot_ca_q  <= slot_ca_d;
      rd_seq_q   <= rd_seq_d;
      wr_seq_q   <= wr_seq_d;
      starve_q   <= starve_d;
    end
  end

  // Pack per-bank slot registers onto the flat request buses.
  assign req_valid = slot_vld_q;
  assign req_wr    = slot_wr_q;
  for (genvar gb = 0; gb < BK_CNT; gb++) begin : g_pack
    assign req_id[gb*ID_W +: ID_W]         = slot_id_q[gb];
    assign req_len[gb*LEN_W +: LEN_W]      = slot_len_q[gb];
    assign req_seq_num[gb*SEQ_W +: SEQ_W]  = slot_seq_q[gb];
    assign req_ra[gb*RA_W +: RA_W]         = slot_ra_q[gb];
    assign req_ca[gb*CA_W +: CA_W]         = slot_ca_q[gb];
  end

endmodule

// File: tb/tb_sal_addr_decoder_dual.sv
// tb_sal_addr_decoder_dual
//   Bench for sal_addr_decoder_dual with default parameters (dut) plus a
//   MAP_MODE=1 instance (dut_m1). Honours SAL_BA_XOR_HASH_EN when defined.
module tb_sal_addr_decoder_dual;

  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic        ar_valid, ar_ready, aw_valid, aw_ready;
  logic [3:0]  ar_id, aw_id;
  logic [7:0]  ar_len, aw_len;
  logic [31:0] ar_addr, aw_addr;
  logic [3:0]  req_valid, req_ready, req_wr;
  logic [15:0] req_id;
  logic [31:0] req_len, req_seq_num;
  logic [55:0] req_ra;
  logic [39:0] req_ca;

  // ---------------- MAP_MODE=1 DUT signals ----------------
  logic        m1_ar_valid, m1_ar_ready, m1_aw_valid, m1_aw_ready;
  logic [3:0]  m1_ar_id, m1_aw_id;
  logic [7:0]  m1_ar_len, m1_aw_len;
  logic [31:0] m1_ar_addr, m1_aw_addr;
  logic [3:0]  m1_req_valid, m1_req_ready, m1_req_wr;
  logic [15:0] m1_req_id;
  logic [31:0] m1_req_len, m1_req_seq_num;
  logic [55:0] m1_req_ra;
  logic [39:0] m1_req_ca;

  sal_addr_decoder_dual #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_len(ar_len), .ar_addr(ar_addr),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_len(aw_len), .aw_addr(aw_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_id(req_id),
    .req_len(req_len), .req_seq_num(req_seq_num), .req_ra(req_ra), .req_ca(req_ca)
  );

  sal_addr_decoder_dual #(.MAP_MODE(1)) dut_m1 (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(m1_ar_valid), .ar_ready(m1_ar_ready), .ar_id(m1_ar_id), .ar_len(m1_ar_len),
    .ar_addr(m1_ar_addr),
    .aw_valid(m1_aw_valid), .aw_ready(m1_aw_ready), .aw_id(m1_aw_id), .aw_len(m1_aw_len),
    .aw_addr(m1_aw_addr),
    .req_valid(m1_req_valid), .req_ready(m1_req_ready), .req_wr(m1_req_wr), .req_id(m1_req_id),
    .req_len(m1_req_len), .req_seq_num(m1_req_seq_num), .req_ra(m1_req_ra), .req_ca(m1_req_ca)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bank slots as plain arrays; counters as integers taken modulo 256.
  bit          m_valid [4];
  logic        m_wr    [4];
  logic [3:0]  m_id    [4];
  logic [7:0]  m_len   [4];
  logic [7:0]  m_seq   [4];
  logic [13:0] m_ra    [4];
  logic [9:0]  m_ca    [4];
  int          m_rd_seq, m_wr_seq, m_starve;

  // Address -> (bank, row, col) with integer arithmetic on the field sizes.
  function automatic void mdecode(input int mode, input logic [31:0] a,
                                  output int ba, output int ra, output int ca);
    longint unsigned w;
    w = {32'b0, a} >> 6;
    if (mode == 0) begin
      ca = int'(w % 1024);
      ba = int'((w / 1024) % 4);
    end else begin
      ba = int'(w % 4);
      ca = int'((w / 4) % 1024);
    end
    ra = int'((w / 4096) % 16384);
`ifdef SAL_BA_XOR_HASH_EN
    ba = ba ^ (ra % 4);
`endif
  endfunction

  function automatic logic [31:0] mk_addr(input int bank, input int row, input int col);
    logic [31:0] a;
    a = 32'(row) * 32'd262144 + 32'(bank) * 32'd65536 + 32'(col) * 32'd64;
    return a;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++) m_valid[b] = 1'b0;
    m_rd_seq = 0;
    m_wr_seq = 0;
    m_starve = 0;
  endtask

  // One clock: check at negedge against the model, advance model at posedge.
  task automatic step();
    int   arb, arr, arc, awb, awr, awc;
    bit   conflict, ar_first, exp_ar, exp_aw;
    logic [3:0] ev;
    @(negedge clk);
    mdecode(0, ar_addr, arb, arr, arc);
    mdecode(0, aw_addr, awb, awr, awc);
    conflict = ar_valid && aw_valid && (arb == awb);
    ar_first = (m_starve == STARVE_MAX);
    if (!rst_n) begin
      exp_ar = 1'b0;
      exp_aw = 1'b0;
    end else begin
      exp_ar = (!m_valid[arb] || req_ready[arb]) && !(conflict && !ar_first);
      exp_aw = (!m_valid[awb] || req_ready[awb]) && !(conflict && ar_first);
    end
    check("ar_ready", 64'(ar_ready), 64'(exp_ar));
    check("aw_ready", 64'(aw_ready), 64'(exp_aw));
    for (int b = 0; b < 4; b++) ev[b] = m_valid[b];
    check("req_valid", 64'(req_valid), 64'(ev));
    for (int b = 0; b < 4; b++) begin
      if (m_valid[b]) begin
        check($sformatf("wr[%0d]", b),  64'(req_wr[b]),             64'(m_wr[b]));
        check($sformatf("id[%0d]", b),  64'(req_id[b*4 +: 4]),      64'(m_id[b]));
        check($sformatf("len[%0d]", b), 64'(req_len[b*8 +: 8]),     64'(m_len[b]));
        check($sformatf("seq[%0d]", b), 64'(req_seq_num[b*8 +: 8]), 64'(m_seq[b]));
        check($sformatf("ra[%0d]", b),  64'(req_ra[b*14 +: 14]),    64'(m_ra[b]));
        check($sformatf("ca[%0d]", b),  64'(req_ca[b*10 +: 10]),    64'(m_ca[b]));
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int b = 0; b < 4; b++) if (m_valid[b] && req_ready[b]) m_valid[b] = 1'b0;
      if (ar_valid && exp_ar) begin
        m_valid[arb] = 1'b1; m_wr[arb] = 1'b0; m_id[arb] = ar_id; m_len[arb] = ar_len;
        m_seq[arb] = 8'(m_rd_seq); m_ra[arb] = 14'(arr); m_ca[arb] = 10'(arc);
        m_rd_seq = (m_rd_seq + 1) % 256;
      end
      if (aw_valid && exp_aw) begin
        m_valid[awb] = 1'b1; m_wr[awb] = 1'b1; m_id[awb] = aw_id; m_len[awb] = aw_len;
        m_seq[awb] = 8'(m_wr_seq); m_ra[awb] = 14'(awr); m_ca[awb] = 10'(awc);
        m_wr_seq = (m_wr_seq + 1) % 256;
      end
      if (ar_valid && exp_ar) m_starve = 0;
      else if (conflict && aw_valid && exp_aw && m_starve < STARVE_MAX) m_starve = m_starve + 1;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ar(input bit v, input logic [31:0] a);
    ar_valid = v;
    ar_addr  = a;
    ar_id    = 4'($urandom_range(0, 15));
    ar_len   = 8'($urandom_range(0, 255));
  endtask

  task automatic drive_aw(input bit v, input logic [31:0] a);
    aw_valid = v;
    aw_addr  = a;
    aw_id    = 4'($urandom_range(0, 15));
    aw_len   = 8'($urandom_range(0, 255));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] grant_pat;
    int         bk, hb, r, c;
    drive_ar(0, '0);
    drive_aw(0, '0);
    req_ready = 4'hF;
    m1_ar_valid = 1'b0; m1_ar_addr = '0; m1_ar_id = '0; m1_ar_len = '0;
    m1_aw_valid = 1'b0; m1_aw_addr = '0; m1_aw_id = '0; m1_aw_len = '0;
    m1_req_ready = 4'hF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset held with requests pending: no readys, no slots.
    drive_ar(1, mk_addr(1, 0, 5));
    drive_aw(1, mk_addr(2, 0, 6));
    repeat (2) step();
    rst_n = 1'b1;
    drive_ar(0, '0);
    drive_aw(0, '0);
    step();
    check("idle_req_valid", 64'(req_valid), 64'h0);

    // AW -> bank 1, AR -> bank 2 in the same cycle.
    drive_aw(1, mk_addr(1, 0, 17));
    drive_ar(1, mk_addr(2, 0, 33));
    #3;
    check("dual_aw_ready", 64'(aw_ready), 64'h1);
    check("dual_ar_ready", 64'(ar_ready), 64'h1);
    step();
    drive_aw(0, '0);
    drive_ar(0, '0);
    #3;
    check("dual_req_valid", 64'(req_valid), 64'b0110);
    check("dual_wr1", 64'(req_wr[1]), 64'h1);
    check("dual_wr2", 64'(req_wr[2]), 64'h0);
    check("dual_seq1", 64'(req_seq_num[15:8]), 64'h0);
    check("dual_seq2", 64'(req_seq_num[23:16]), 64'h0);
    step();

    // Held same-bank conflict on bank 3: AW x4, AR, AW x4, AR.
    grant_pat = 10'b1111011110;
    drive_aw(1, mk_addr(3, 0, 1));
    drive_ar(1, mk_addr(3, 0, 2));
    for (int i = 0; i < 10; i++) begin
      #3;
      check($sformatf("grant_aw[%0d]", i), 64'(aw_ready), 64'(grant_pat[9 - i]));
      check($sformatf("grant_ar[%0d]", i), 64'(ar_ready), 64'(!grant_pat[9 - i]));
      step();
    end
    drive_aw(0, '0);
    drive_ar(0, '0);
    step();

    // Backpressure on bank 0: fill, stall AR, then pop and push together.
    req_ready = 4'b1110;
    drive_aw(1, mk_addr(0, 0, 9));
    step();
    drive_aw(0, '0);
    drive_ar(1, mk_addr(0, 0, 10));
    for (int i = 0; i < 3; i++) begin
      #3;
      check("bp_ar_ready", 64'(ar_ready), 64'h0);
      step();
    end
    req_ready = 4'hF;
    #3;
    check("bp_release_ar_ready", 64'(ar_ready), 64'h1);
    step();
    drive_ar(0, '0);
    #3;
    check("bp_push_valid", 64'(req_valid[0]), 64'h1);
    check("bp_push_wr", 64'(req_wr[0]), 64'h0);
    step();

    // Sequence wrap: after reset, 260 AR accepts, seq = count mod 256.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bk = int'($urandom_range(0, 3));
      drive_ar(1, mk_addr(bk, 0, int'($urandom_range(0, 1023))));
      step();
      #3;
      check("wrap_seq", 64'(req_seq_num[bk*8 +: 8]), 64'(i % 256));
    end
    drive_ar(0, '0);
    step();

    // Randomized traffic with backpressure and a mid-run reset pulse.
    for (int i = 0; i < 1500; i++) begin
      rst_n = !(i >= 700 && i < 702);
      req_ready = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 1023));
      drive_ar($urandom_range(0, 3) != 0,
               mk_addr(int'($urandom_range(0, 3)), r, c));
      drive_aw($urandom_range(0, 3) != 0,
               mk_addr(int'($urandom_range(0, 3)), int'($urandom_range(0, 16383)),
                       int'($urandom_range(0, 1023))));
      step();
    end
    rst_n = 1'b1;
    drive_ar(0, '0);
    drive_aw(0, '0);
    req_ready = 4'hF;
    step();

    // Row-hashed bank select: RA = 1, BA = 0.
`ifdef SAL_BA_XOR_HASH_EN
    hb = 1;
`else
    hb = 0;
`endif
    drive_ar(1, mk_addr(0, 1, 0));
    step();
    drive_ar(0, '0);
    #3;
    check("hash_bank", 64'(req_valid), 64'(4'b0001 << hb));
    step();

    // MAP_MODE = 1 instance: addr 0xC0 decodes to bank 3.
    m1_ar_valid = 1'b1;
    m1_ar_addr  = 32'h0000_00C0;
    m1_ar_id    = 4'h5;
    m1_ar_len   = 8'h07;
    #3;
    check("m1_ar_ready", 64'(m1_ar_ready), 64'h1);
    @(posedge clk);
    #1;
    m1_ar_valid = 1'b0;
    #3;
    check("m1_req_valid", 64'(m1_req_valid), 64'b1000);
    check("m1_req_wr", 64'(m1_req_wr[3]), 64'h0);
    check("m1_req_id", 64'(m1_req_id[15:12]), 64'h5);
    check("m1_req_len", 64'(m1_req_len[31:24]), 64'h07);
    check("m1_req_ra", 64'(m1_req_ra[55:42]), 64'h0);
    check("m1_req_ca", 64'(m1_req_ca[39:30]), 64'h0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule
